// File: rtl/conv8_ctrl.sv
// conv8_ctrl: tile sequencer for the 8-row 3x3 convolution core.
//
// Accepts a tile command. Fetches three weight columns and n_cols pixel columns from
// single-cycle-latency buffers and feeds them to the core. Keeps core_en high through the
// pipeline drain, tags each valid output column with res_valid/res_idx, and ends each tile
// with a one-cycle done pulse. err is raised together with done on an illegal n_cols or an
// abort.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   start, n_cols      tile request and its column count (sampled when idle)
//   abort              terminate the running tile
//   busy, done, err    tile status
//   w_rd, w_addr       weight buffer read strobe / column index; w_rdata returns a cycle later
//   x_rd, x_addr       feature buffer read strobe / column index; x_rdata returns a cycle later
//   core_en            core enable
//   core_r, core_f     core pixel / weight inputs, zero when no read returned this cycle
//   res_valid, res_idx core sums hold output column res_idx
module conv8_ctrl #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_COLS = 64,
  parameter int unsigned COL_W    = $clog2(MAX_COLS + 1),
  parameter int unsigned CORE_LAT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [COL_W-1:0]     n_cols,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 w_rd,
  output logic [1:0]           w_addr,
  input  logic [3*WIDTH-1:0]   w_rdata,
  output logic                 x_rd,
  output logic [COL_W-1:0]     x_addr,
  input  logic [8*WIDTH-1:0]   x_rdata,
  output logic                 core_en,
  output logic [8*WIDTH-1:0]   core_r,
  output logic [3*WIDTH-1:0]   core_f,
  output logic                 res_valid,
  output logic [COL_W-1:0]     res_idx
);

  // The tile cycle counter must reach n_cols + CORE_LAT + 2.
  localparam int unsigned CYC_W = $clog2(MAX_COLS + CORE_LAT + 3);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e             state_q, state_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [COL_W-1:0]   n_q, n_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               w_rd_q, w_rd_d;
  logic [1:0]         w_addr_q, w_addr_d;
  logic               x_rd_q, x_rd_d;
  logic [COL_W-1:0]   x_addr_q, x_addr_d;
  logic               core_en_q, core_en_d;
  logic               res_valid_q, res_valid_d;
  logic [COL_W-1:0]   res_idx_q, res_idx_d;
  // Read-returned flags: buffer data is valid in the cycle after a strobe.
  logic               x_vld_q, x_vld_d;
  logic               w_vld_q, w_vld_d;

  logic               legal;
  logic [CYC_W-1:0]   cyc_nx;
  logic [CYC_W-1:0]   n_ext;
  logic [CYC_W-1:0]   end_cyc;

  assign legal   = (n_cols >= COL_W'(3)) && (n_cols <= COL_W'(MAX_COLS));
  assign cyc_nx  = cyc_q + CYC_W'(1);
  assign n_ext   = CYC_W'(n_q);
  assign end_cyc = n_ext + CYC_W'(CORE_LAT + 2);

  // Registered outputs for the next cycle are derived from the next tile-cycle index cyc_nx.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    n_d         = n_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    w_rd_d      = 1'b0;
    w_addr_d    = '0;
    x_rd_d      = 1'b0;
    x_addr_d    = '0;
    core_en_d   = 1'b0;
    res_valid_d = 1'b0;
    res_idx_d   = res_valid_q ? res_idx_q + COL_W'(1) : res_idx_q;
    x_vld_d     = x_rd_q;
    w_vld_d     = w_rd_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (legal) begin
            state_d   = StRun;
            n_d       = n_cols;
            cyc_d     = CYC_W'(1);
            busy_d    = 1'b1;
            x_rd_d    = 1'b1;
            w_rd_d    = 1'b1;
            res_idx_d = '0;
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      StRun, StDrain: begin
        if (abort) begin
          // Kill data returning from reads already in flight as well.
          state_d = StIdle;
          done_d  = 1'b1;
          err_d   = 1'b1;
          x_vld_d = 1'b0;
          w_vld_d = 1'b0;
        end else if (cyc_nx == end_cyc) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cyc_d       = cyc_nx;
          busy_d      = 1'b1;
          core_en_d   = 1'b1;
          x_rd_d      = (cyc_nx <= n_ext);
          w_rd_d      = (cyc_nx <= CYC_W'(3));
          x_addr_d    = x_rd_d ? cyc_q[COL_W-1:0] : '0;
          w_addr_d    = w_rd_d ? cyc_q[1:0] : 2'd0;
          res_valid_d = (cyc_nx >= CYC_W'(CORE_LAT + 4)) &&
                        (cyc_nx <= n_ext + CYC_W'(CORE_LAT + 1));
          state_d     = x_rd_d ? StRun : StDrain;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cyc_q       <= '0;
      n_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      w_rd_q      <= 1'b0;
      w_addr_q    <= '0;
      x_rd_q      <= 1'b0;
      x_addr_q    <= '0;
      core_en_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      x_vld_q     <= 1'b0;
      w_vld_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      n_q         <= n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      w_rd_q      <= w_rd_d;
      w_addr_q    <= w_addr_d;
      x_rd_q      <= x_rd_d;
      x_addr_q    <= x_addr_d;
      core_en_q   <= core_en_d;
      res_valid_q <= res_valid_d;
      res_idx_q   <= res_idx_d;
      x_vld_q     <= x_vld_d;
      w_vld_q     <= w_vld_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign w_rd      = w_rd_q;
  assign w_addr    = w_addr_q;
  assign x_rd      = x_rd_q;
  assign x_addr    = x_addr_q;
  assign core_en   = core_en_q;
  assign res_valid = res_valid_q;
  assign res_idx   = res_idx_q;
  assign core_r    = x_vld_q ? x_rdata : '0;
  assign core_f    = w_vld_q ? w_rdata : '0;

endmodule

// File: tb/tb_conv8_ctrl.sv
// Self-checking bench for conv8_ctrl: directed tiles from the test plan plus randomized tiles,
// checked cycle by cycle against a model built from the tile timing rules.
module tb_conv8_ctrl;

  localparam int W  = 8;
  localparam int MC = 64;
  localparam int CW = $clog2(MC + 1);
  localparam int L  = 3;

  logic            clk;
  logic            rst;
  logic            start;
  logic [CW-1:0]   n_cols;
  logic            abort;
  logic            busy, done, err;
  logic            w_rd;
  logic [1:0]      w_addr;
  logic [3*W-1:0]  w_rdata;
  logic            x_rd;
  logic [CW-1:0]   x_addr;
  logic [8*W-1:0]  x_rdata;
  logic            core_en;
  logic [8*W-1:0]  core_r;
  logic [3*W-1:0]  core_f;
  logic            res_valid;
  logic [CW-1:0]   res_idx;

  logic [8*W-1:0]  xmem [MC];
  logic [3*W-1:0]  wmem [3];

  int vectors = 0;
  int miscompares = 0;

  conv8_ctrl #(
    .WIDTH    (W),
    .MAX_COLS (MC),
    .COL_W    (CW),
    .CORE_LAT (L)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .n_cols    (n_cols),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .w_rd      (w_rd),
    .w_addr    (w_addr),
    .w_rdata   (w_rdata),
    .x_rd      (x_rd),
    .x_addr    (x_addr),
    .x_rdata   (x_rdata),
    .core_en   (core_en),
    .core_r    (core_r),
    .core_f    (core_f),
    .res_valid (res_valid),
    .res_idx   (res_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-cycle-latency buffers.
  always @(posedge clk) begin
    if (x_rd) x_rdata <= xmem[x_addr];
    if (w_rd) w_rdata <= wmem[w_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int t, input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s cycle %0d: got %0h expected %0h", tag, t, got, exp);
    end
  endtask

  task automatic check_idle(input int t);
    chk("idle_busy", t, busy, 0);
    chk("idle_done", t, done, 0);
    chk("idle_err", t, err, 0);
    chk("idle_x_rd", t, x_rd, 0);
    chk("idle_w_rd", t, w_rd, 0);
    chk("idle_core_en", t, core_en, 0);
    chk("idle_res_valid", t, res_valid, 0);
    chk("idle_core_r", t, core_r, 0);
    chk("idle_core_f", t, core_f, 0);
  endtask

  // Expected outputs of tile cycle t; the tile ends (done) in cycle e.
  task automatic check_cycle(input int t, input int n, input int e, input bit err_exp);
    bit act;
    bit xr, wr, rv;
    logic [63:0] er, ef;
    act = (t < e);
    xr  = act && (t <= n);
    wr  = act && (t <= 3);
    rv  = act && (t >= 4 + L) && (t <= n + 1 + L);
    er  = (act && t >= 2 && t <= n + 1) ? 64'(xmem[t-2]) : 64'd0;
    ef  = (act && t >= 2 && t <= 4) ? 64'(wmem[t-2]) : 64'd0;
    chk("busy", t, busy, act);
    chk("done", t, done, t == e);
    chk("err", t, err, (t == e) && err_exp);
    chk("x_rd", t, x_rd, xr);
    if (xr) chk("x_addr", t, x_addr, t - 1);
    chk("w_rd", t, w_rd, wr);
    if (wr) chk("w_addr", t, w_addr, t - 1);
    chk("core_en", t, core_en, act && t >= 2);
    chk("res_valid", t, res_valid, rv);
    if (rv) chk("res_idx", t, res_idx, t - 4 - L);
    chk("core_r", t, core_r, er);
    chk("core_f", t, core_f, ef);
  endtask

  // Called in cycle 0 of a tile.
  task automatic launch(input int n);
    start  = 1'b1;
    n_cols = CW'(n);
  endtask

  // Runs a tile already launched in the current cycle. abort_at>0 raises abort in that cycle;
  // chain_n>=0 holds start high (with n_cols=chain_n) throughout, launching the next tile
  // in the done cycle.
  task automatic run_tile(input int n, input int abort_at, input int chain_n);
    bit legal, ab;
    int e;
    legal = (n >= 3) && (n <= MC);
    e     = legal ? n + 2 + L : 1;
    ab    = legal && (abort_at >= 1) && (abort_at < e);
    if (ab) e = abort_at + 1;
    for (int t = 1; t <= e; t++) begin
      step();
      check_cycle(t, n, e, !legal || ab);
      start = (chain_n >= 0);
      if (chain_n >= 0) n_cols = CW'(chain_n);
      abort = ab && (t == abort_at);
    end
    abort = 1'b0;
  endtask

  task automatic fill_plan();
    for (int c = 0; c < MC; c++) xmem[c] = {8{8'(c + 1)}};
    wmem[0] = {8'd7, 8'd4, 8'd1};
    wmem[1] = {8'd8, 8'd5, 8'd2};
    wmem[2] = {8'd9, 8'd6, 8'd3};
  endtask

  task automatic fill_rand();
    for (int c = 0; c < MC; c++) xmem[c] = {$urandom, $urandom};
    for (int k = 0; k < 3; k++) wmem[k] = 24'($urandom);
  endtask

  initial begin
    int n, ab;
    rst = 1'b1; start = 1'b0; abort = 1'b0; n_cols = '0;
    x_rdata = '0; w_rdata = '0;
    fill_plan();
    repeat (2) @(posedge clk);
    #1 check_idle(0);
    rst = 1'b0;
    step(); check_idle(0);

    // Plan tile N=8, then N=3.
    launch(8); run_tile(8, 0, -1); step(); check_idle(0);
    launch(3); run_tile(3, 0, -1); step(); check_idle(0);

    // Illegal counts.
    launch(2);  run_tile(2, 0, -1);  step(); check_idle(0);
    launch(65); run_tile(65, 0, -1); step(); check_idle(0);

    // Back-to-back with start held through the done cycle.
    launch(4); run_tile(4, 0, 4); run_tile(4, 0, -1); step(); check_idle(0);

    // Abort in cycle 5, then abort while idle is ignored.
    launch(8); run_tile(8, 5, -1); step(); check_idle(0);
    abort = 1'b1; step(); abort = 1'b0; check_idle(0);
    step(); check_idle(0);

    // Reset pulse in cycle 4 with start asserted during reset.
    launch(8);
    for (int t = 1; t <= 4; t++) begin
      step(); check_cycle(t, 8, 13, 1'b0);
      start = 1'b0;
    end
    rst = 1'b1; start = 1'b1; n_cols = CW'(8);
    #1 check_idle(4);
    step(); check_idle(5);
    rst = 1'b0; start = 1'b0;
    step(); check_idle(6);
    launch(8); run_tile(8, 0, -1); step(); check_idle(0);

    // Randomized tiles, including illegal counts and aborts.
    for (int i = 0; i < 10; i++) begin
      fill_rand();
      n  = $urandom_range(0, 20);
      ab = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n + 1 + L) : 0;
      launch(n); run_tile(n, ab, -1); step(); check_idle(0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/conv8_ctrl.md
# conv8_ctrl

Sequencer for the 8-row, 3x3 convolution core. It accepts a tile command and fetches the three weight columns and `n_cols` input pixel columns from single-cycle-latency buffers. It presents them to the core with correct alignment, drives the core enable through the pipeline drain, and tags each valid output column. It sits between the feature/weight buffers and `Conv8_core`; the core's `o_sum1..o_sum4` bypass this block and are qualified by `res_valid`.

## Interface
Parameters:
- `WIDTH`, default 8: pixel/weight width; equals `definition::width`.
- `MAX_COLS`, default 64: largest legal `n_cols`.
- `COL_W`, default `$clog2(MAX_COLS+1)`: column counter/address width.
- `CORE_LAT`, default 3: cycles from presenting input column j+2 to the core until `o_sum*` of output column j is valid.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  tile request; accepted only when idle.
- `n_cols`  in  COL_W  input columns in the tile; sampled on accepted `start`.
- `abort`  in  1  terminate the running tile.
- `busy`  out  1  tile in progress.
- `done`  out  1  one-cycle end-of-tile pulse.
- `err`  out  1  one-cycle pulse, coincident with `done`, on an illegal `n_cols` or an abort.
- `w_rd`  out  1  weight buffer read strobe.
- `w_addr`  out  2  weight column index 0..2.
- `w_rdata`  in  3*WIDTH  {f3,f2,f1}; valid one cycle after `w_rd`.
- `x_rd`  out  1  feature buffer read strobe.
- `x_addr`  out  COL_W  input column index.
- `x_rdata`  in  8*WIDTH  {r8..r1}; valid one cycle after `x_rd`.
- `core_en`  out  1  to core `en`.
- `core_r`  out  8*WIDTH  to core `i_r8..i_r1`.
- `core_f`  out  3*WIDTH  to core `i_f3..i_f1`.
- `res_valid`  out  1  core `o_sum1..4` hold output column `res_idx`.
- `res_idx`  out  COL_W  output column index 0..n_cols-3.

## Operation
- States: IDLE, RUN (issue reads), DRAIN (zeros into core until the last result), plus a one-cycle DONE pulse that is taken while returning to IDLE.
- Reset values: IDLE, and every output 0, including `core_r` and `core_f`.
- `start` outside IDLE is ignored. `start` in the cycle in which `done` is high is accepted, so tiles run back-to-back.
- Legal range is 3 <= `n_cols` <= `MAX_COLS`.
  - An illegal value raises `done` and `err` in the next cycle.
  - No reads are issued and `busy` stays 0.
- Reads:
  - Column counter c runs 0..n_cols-1 with `x_addr`=c.
  - Weight counter k runs 0..2 with `w_addr`=k, issued in parallel with the first three x reads.
- Data zeroing:
  - `core_r` = `x_rdata` when `x_rd` was high in the previous cycle (registered flag), else 0.
  - `core_f` = `w_rdata` when `w_rd` was high in the previous cycle, else 0.
- The result counter increments on each `res_valid` and wraps to 0 at tile start.
- Abort:
  - `abort` in RUN or DRAIN moves the block to IDLE at the next edge. `done`=`err`=1 for that cycle.
  - `core_en`, `res_valid`, reads and data outputs go to 0 from that cycle.
  - `abort` in IDLE is ignored. `abort` has priority over natural completion in the same cycle.
- Asserting `rst` mid-tile clears all outputs immediately. A new tile requires a fresh `start` after `rst` is released.

## Timing
Cycle 0 is the cycle in which `start` is sampled high in IDLE. N = `n_cols`, L = `CORE_LAT`.
- `busy`=1 in cycles 1..N+1+L.
- `x_rd`=1 in cycles 1..N, with `x_addr`=cycle-1. `core_r` carries column c in cycle c+2.
- `w_rd`=1 in cycles 1..3, with `w_addr`=cycle-1. `core_f` carries weight column k in cycle k+2.
- `core_en`=1 in cycles 2..N+1+L.
- `res_valid`=1 with `res_idx`=j in cycle j+4+L, for j=0..N-3.
- `done`=1 in cycle N+2+L, with `busy`=0 and `core_en`=0 in that cycle.
- Outputs are registered, except the `core_r`/`core_f` muxes, which are fed only by registered flags and buffer data.

## Test plan
- N=8, L=3, x column c = all bytes c+1, weights {7,4,1},{8,5,2},{9,6,3}:
  - `x_rd` in cycles 1..8 with addr 0..7; `w_rd` in cycles 1..3 with addr 0..2.
  - `core_r` bytes 1..8 in cycles 2..9, 0 in cycles 10..12; `core_f` nonzero only in cycles 2..4.
  - `core_en` in cycles 2..12; `res_valid` in cycles 7..12 with idx 0..5; `done` in cycle 13, `err`=0.
- N=3: one `res_valid` in cycle 7 with idx 0; `done` in cycle 8.
- N=2, then N=65: `done`=`err`=1 in cycle 1; `x_rd`, `w_rd`, `busy` and `core_en` never set.
- N=4 with `start` held through the `done` cycle: second tile's `busy`=1 in the following cycle; second tile's `res_idx` restarts at 0.
- N=8, `abort` in cycle 5: cycle 6 has `done`=`err`=1 and `busy`=`core_en`=`res_valid`=0; no further reads.
- `rst` pulsed in cycle 4 of N=8: all outputs 0 at once; `start` during `rst` is ignored; a `start` after release runs a normal tile.
